// File: rtl/pwm_multichannel.sv
// pwm_multichannel
//   NUM_CH independent PWM channels sharing one programmable period and one
//   clock prescaler. Duty and period writes land in shadow registers and are
//   copied to the active registers only on a period wrap, so a pulse in
//   flight is never cut short or stretched.
//
// Ports
//   clk           system clock
//   rst           synchronous, active-high reset
//   wr_en         write strobe, one register write per asserted cycle
//   wr_addr       0..NUM_CH-1 selects duty[ch], NUM_CH selects period,
//                 anything above is ignored
//   wr_data       value written to the selected shadow register
//   ch_en         per-channel output enable (not shadowed)
//   ch_pwm        per-channel mode: 1 = PWM, 0 = static high when enabled
//   pwm_out       registered channel outputs
//   period_strobe one-cycle pulse, one cycle after each period wrap
module pwm_multichannel #(
  parameter int NUM_CH    = 8,
  parameter int CNT_W     = 8,
  parameter int PRESC_DIV = 3333,
  parameter int AW        = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [CNT_W-1:0]  wr_data,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [NUM_CH-1:0] ch_pwm,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_strobe
);

  localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_DIV - 1);

  logic [PW-1:0]    presc;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] duty_sh  [NUM_CH];
  logic [CNT_W-1:0] duty_act [NUM_CH];
  logic [CNT_W-1:0] per_sh;
  logic [CNT_W-1:0] per_act;
  logic             tick;
  logic             wrap;

  // Unsigned CNT_W-bit compare; a duty above per_act therefore never
  // releases the output, and duty 0 never raises it.
  function automatic logic duty_hit(input logic [CNT_W-1:0] c,
                                    input logic [CNT_W-1:0] d);
    return (c < d);
  endfunction

  assign tick = (presc == PRESC_LAST);
  assign wrap = tick && (cnt == per_act);

  // Timebase: prescaler and period counter
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      cnt   <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        cnt <= wrap ? '0 : cnt + 1'b1;
      end
    end
  end

  // Register bank: shadows take writes; actives reload from the pre-write
  // shadow values on wrap (non-blocking read gives the old value when a
  // write lands on the wrap cycle).
  always_ff @(posedge clk) begin
    if (rst) begin
      per_sh  <= '1;
      per_act <= '1;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_sh[i]  <= '0;
        duty_act[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (wr_addr == AW'(i)) duty_sh[i] <= wr_data;
        end
        if (wr_addr == AW'(NUM_CH)) per_sh <= wr_data;
      end
      if (wrap) begin
        per_act <= per_sh;
        for (int i = 0; i < NUM_CH; i++) begin
          duty_act[i] <= duty_sh[i];
        end
      end
    end
  end

  // Output stage: one registered cycle after cnt / duty_act / ch_en / ch_pwm
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_out       <= '0;
      period_strobe <= 1'b0;
    end else begin
      period_strobe <= wrap;
      for (int i = 0; i < NUM_CH; i++) begin
        pwm_out[i] <= ch_en[i] & (~ch_pwm[i] | duty_hit(cnt, duty_act[i]));
      end
    end
  end

endmodule

// File: tb/tb_pwm_multichannel.sv
module tb_pwm_multichannel;

  localparam int NUM_CH    = 4;
  localparam int CNT_W     = 4;
  localparam int PRESC_DIV = 2;
  localparam int AW        = 5;

  logic              clk;
  logic              rst;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [CNT_W-1:0]  wr_data;
  logic [NUM_CH-1:0] ch_en;
  logic [NUM_CH-1:0] ch_pwm;
  logic [NUM_CH-1:0] pwm_out;
  logic              period_strobe;

  int n_checks = 0;
  int n_pass   = 0;
  int hi, st, n;

  pwm_multichannel #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESC_DIV(PRESC_DIV), .AW(AW)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .ch_en(ch_en), .ch_pwm(ch_pwm),
    .pwm_out(pwm_out), .period_strobe(period_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  // Drive a write at the current negedge; it lands on the next posedge.
  task automatic do_write(input int addr, input int data);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = CNT_W'(data);
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // Cycles until period_strobe is seen; -1 if it never shows within maxc.
  task automatic wait_strobe(input int maxc, output int cyc);
    bit found = 0;
    cyc = 0;
    while (!found && cyc < maxc) begin
      @(negedge clk);
      cyc++;
      if (period_strobe) found = 1;
    end
    if (!found) cyc = -1;
  endtask

  // High cycles of one channel and strobe count over the next ncyc samples.
  task automatic measure(input int ch, input int ncyc, output int h, output int s);
    h = 0;
    s = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (pwm_out[ch]) h++;
      if (period_strobe) s++;
    end
  endtask

  initial begin
    rst     = 1'b1;
    ch_en   = 4'b0001;
    ch_pwm  = 4'b0001;
    // write during reset must be dropped
    wr_en   = 1'b1;
    wr_addr = AW'(4);
    wr_data = CNT_W'(3);
    repeat (3) @(negedge clk);
    chk("reset_pwm", int'(pwm_out), 0);
    chk("reset_strobe", int'(period_strobe), 0);
    rst   = 1'b0;
    wr_en = 1'b0;
    wait_strobe(100, n);
    chk("first_wrap_after_reset", n, 32);
    wait_strobe(100, n);
    chk("second_period_default", n, 32);

    // Basic PWM: period 9, duty 3
    do_write(4, 9);
    do_write(0, 3);
    wait_strobe(100, n);
    measure(0, 20, hi, st);
    chk("basic_high", hi, 6);
    chk("basic_strobes", st, 1);
    measure(0, 20, hi, st);
    chk("basic_high_2", hi, 6);
    wait_strobe(100, n);
    chk("basic_period", n, 20);

    // Shadow update mid-period
    fork
      measure(0, 20, hi, st);
      begin
        repeat (3) @(negedge clk);
        do_write(0, 7);
      end
    join
    chk("shadow_cur_period", hi, 6);
    measure(0, 20, hi, st);
    chk("shadow_next_period", hi, 14);

    // Write landing exactly on the wrap edge
    repeat (19) @(negedge clk);
    do_write(0, 3);
    chk("write_on_wrap_strobe", int'(period_strobe), 1);
    measure(0, 20, hi, st);
    chk("wrap_write_old_active", hi, 14);
    measure(0, 20, hi, st);
    chk("wrap_write_new_active", hi, 6);

    // Boundaries
    do_write(0, 0);
    wait_strobe(100, n);
    measure(0, 20, hi, st);
    chk("duty0_low", hi, 0);
    do_write(0, 10);
    wait_strobe(100, n);
    measure(0, 20, hi, st);
    chk("duty10_high", hi, 20);
    do_write(0, 15);
    wait_strobe(100, n);
    measure(0, 20, hi, st);
    chk("duty15_high", hi, 20);
    do_write(0, 1);
    do_write(4, 0);
    wait_strobe(100, n);
    measure(0, 20, hi, st);
    chk("per0_high", hi, 20);
    chk("per0_strobes", st, 10);
    wait_strobe(100, n);
    chk("per0_period", n, 2);

    // Modes and enables
    ch_en  = 4'b0011;
    ch_pwm = 4'b0001;
    @(negedge clk);
    chk("static_on", int'(pwm_out), 3);
    ch_en = 4'b0001;
    @(negedge clk);
    chk("static_off", int'(pwm_out), 1);
    do_write(5, 9);
    ch_en  = 4'b0011;
    ch_pwm = 4'b0011;
    wait_strobe(100, n);
    wait_strobe(100, n);
    chk("addr5_period_kept", n, 2);
    measure(1, 20, hi, st);
    chk("addr5_duty1_kept", hi, 0);
    measure(0, 20, hi, st);
    chk("addr5_duty0_kept", hi, 20);

    // Reset mid-operation at cnt = 5
    ch_pwm = 4'b0001;
    do_write(4, 9);
    do_write(0, 15);
    wait_strobe(100, n);
    repeat (10) @(negedge clk);
    chk("pre_reset_high", int'(pwm_out), 3);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_pwm", int'(pwm_out), 0);
    chk("midreset_strobe", int'(period_strobe), 0);
    rst = 1'b0;
    wait_strobe(100, n);
    chk("midreset_first_wrap", n, 32);
    measure(0, 32, hi, st);
    chk("midreset_duty_cleared", hi, 0);
    chk("midreset_period_default", st, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
